// File: rtl/cache_req_fifo.sv
// Cache request FIFO: buffers {we, addr, data, wstrb} packets from the AXI-Lite slave
// and presents them to the cache core first-word-fall-through over a valid/ready handshake.
package cache_pkg;
  parameter int ADDR_WIDTH = 32;
  parameter int DATA_WIDTH = 32;
endpackage

module cache_req_fifo #(
  parameter int ADDR_WIDTH = cache_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = cache_pkg::DATA_WIDTH,
  parameter int DATA_BYTES = DATA_WIDTH / 8,
  parameter int FIFO_WIDTH = 1 + ADDR_WIDTH + DATA_WIDTH + DATA_BYTES,
  parameter int DEPTH      = 8
) (
  input  logic                        aclk_i,
  input  logic                        arstn_i,
  input  logic [FIFO_WIDTH-1:0]       pkt_data_i,
  input  logic                        pkt_valid_i,
  output logic                        pkt_ready_o,
  output logic                        req_valid_o,
  input  logic                        req_ready_i,
  output logic                        req_we_o,
  output logic [ADDR_WIDTH-1:0]       req_addr_o,
  output logic [DATA_WIDTH-1:0]       req_wdata_o,
  output logic [DATA_BYTES-1:0]       req_wstrb_o,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic                        full_o,
  output logic                        empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [FIFO_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      w_count_next;
  logic                  r_pkt_ready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_not_empty;
  logic [FIFO_WIDTH-1:0] w_head;

  assign w_not_empty = (r_count != '0);
  assign w_push      = pkt_valid_i & r_pkt_ready;
  assign w_pop       = w_not_empty & req_ready_i;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - CNT_W'(1);
    end
  end

  // Ready is a flop of "not full next cycle", so the cache-side ready never reaches the slave
  // combinationally; it stays low through reset and rises on the first edge after release.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pkt_ready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count     <= w_count_next;
      r_pkt_ready <= (w_count_next != CNT_W'(DEPTH));
    end
  end

  // NOTE: the storage array has no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge aclk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= pkt_data_i;
  end

  assign w_head = r_mem[r_rd_ptr];

  // Fields are forced to zero while empty so nothing undefined leaks out of the unreset storage.
  always_comb begin
    req_we_o    = 1'b0;
    req_addr_o  = '0;
    req_wdata_o = '0;
    req_wstrb_o = '0;
    if (w_not_empty) begin
      req_we_o    = w_head[FIFO_WIDTH-1];
      req_addr_o  = w_head[FIFO_WIDTH-2 -: ADDR_WIDTH];
      req_wdata_o = w_head[DATA_BYTES +: DATA_WIDTH];
      req_wstrb_o = w_head[FIFO_WIDTH-1] ? w_head[DATA_BYTES-1:0] : '0;
    end
  end

  assign pkt_ready_o = r_pkt_ready;
  assign req_valid_o = w_not_empty;
  assign count_o     = r_count;
  assign full_o      = (r_count == CNT_W'(DEPTH));
  assign empty_o     = !w_not_empty;

endmodule

// File: doc/cache_req_fifo.md
Name: cache_req_fifo

Overview:
- Downstream consumer of the packet stream produced by axi_4_lite_slave (data_pkt/valid_pkt/ready_pkt).
- Buffers packets in a DEPTH-entry circular FIFO, decodes each into a cache request (op, address, data, byte strobes) and presents it to the cache core through a valid/ready handshake.
- Decouples AXI-side bursts from cache-side stalls.

Parameters:
- ADDR_WIDTH, 32, request address width (from cache_pkg)
- DATA_WIDTH, 32, data width (from cache_pkg)
- DATA_BYTES, DATA_WIDTH/8, number of byte strobes
- FIFO_WIDTH, 1+ADDR_WIDTH+DATA_WIDTH+DATA_BYTES, packet width; layout MSB..LSB = {we, addr, data, wstrb}
- DEPTH, 8, number of entries; power of two, minimum 2

Ports:
- aclk_i  in  1  clock, all logic on rising edge
- arstn_i  in  1  asynchronous active-low reset
- pkt_data_i  in  FIFO_WIDTH  packet from slave data_pkt_o
- pkt_valid_i  in  1  packet valid from slave valid_pkt_o
- pkt_ready_o  out  1  to slave ready_pkt_i; high when not full
- req_valid_o  out  1  cache request valid
- req_ready_i  in  1  cache accepts request
- req_we_o  out  1  1 = write, 0 = read
- req_addr_o  out  ADDR_WIDTH  request address
- req_wdata_o  out  DATA_WIDTH  write data; don't-care for reads
- req_wstrb_o  out  DATA_BYTES  byte strobes; forced to 0 for reads
- count_o  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
- full_o  out  1  count_o == DEPTH
- empty_o  out  1  count_o == 0

Behaviour:
- Reset (arstn_i low, asynchronous): wr_ptr = 0, rd_ptr = 0, count = 0.
  - Outputs during reset: pkt_ready_o = 0, req_valid_o = 0, empty_o = 1, full_o = 0, count_o = 0, req_* fields = 0.
  - Storage array is not reset.
  - pkt_ready_o rises on the first clock edge after reset deassertion.
  - Reset mid-operation discards all entries; no request is replayed.
- Push: pkt_valid_i & pkt_ready_o at an edge writes mem[wr_ptr] and increments wr_ptr modulo DEPTH.
- pkt_ready_o = !full, registered. It does not depend combinationally on req_ready_i, so no combinational path exists from the cache to the slave.
- Pop: req_valid_o & req_ready_i at an edge increments rd_ptr modulo DEPTH.
- Output stage is first-word-fall-through:
  - req_valid_o = !empty.
  - req_* fields decode mem[rd_ptr] combinationally from the stored packet.
  - Latency: packet pushed at edge N into an empty FIFO gives req_valid_o = 1 after edge N (visible in cycle N+1).
- Holding rule: while req_valid_o = 1 and req_ready_i = 0, all req_* fields stay stable.
- Decode:
  - req_we_o = pkt[FIFO_WIDTH-1].
  - req_addr_o = next ADDR_WIDTH bits, then req_wdata_o, then req_wstrb_o in the LSBs.
  - When req_we_o = 0, req_wstrb_o = 0.
- Count update per edge: push & !pop gives +1; pop & !push gives -1; both or neither leave it unchanged.
- Boundaries:
  - Full: pkt_ready_o = 0 and pkt_valid_i is ignored. A pop in the same cycle frees a slot, so pkt_ready_o = 1 from the next cycle.
  - Empty: req_ready_i is ignored and no pointer moves.
  - Simultaneous push and pop at count = 1: the popped entry is the old one, the pushed entry becomes head, count stays 1, req_valid_o stays 1.
  - Pointer wrap: after DEPTH pushes wr_ptr returns to 0; ordering is strictly FIFO across the wrap.

Test Plan:
- Reset: hold arstn_i low 5 cycles. pkt_ready_o = 0, req_valid_o = 0, empty_o = 1, count_o = 0. After release, pkt_ready_o = 1 after one edge.
- Single write: push {we=1, addr=0, data=32'd1, wstrb=4'hF} with req_ready_i = 1. req_valid_o is high one cycle after the push with addr=0, wdata=1, wstrb=F. It is popped; count returns to 0.
- Read decode: push {we=0, addr=32'd5, data=32'hDEADBEEF, wstrb=4'hF}. Outputs are req_we_o = 0, req_addr_o = 5, req_wstrb_o = 0.
- Fill/backpressure: req_ready_i = 0, push data 1..9 back-to-back.
  - Exactly 8 accepted; full_o = 1, pkt_ready_o = 0, count_o = 8; the 9th is held by the slave.
  - Raise req_ready_i: requests drain in order 1..8 with stable fields while stalled, then the 9th arrives.
- Simultaneous push/pop: at count_o = 1 push data 32'd5 while popping. count_o stays 1 and the next head is data 5.
- Wrap and reset: stream 20 packets with req_ready_i toggling each cycle; all emerge in order with none lost. Then assert arstn_i with 3 entries held: count_o = 0 immediately and req_valid_o = 0.
